// File: rtl/puf_key_generator_if.sv
// ---------------------------------------------------------------------------
// puf_key_generator_if
// Challenge/response link between the key generator (initiator) and the PUF
// core.
//   challenge [7:0] : challenge word presented to the PUF core
//   response        : one-bit PUF answer for the current challenge
// Modports:
//   master : key generator side (drives challenge, reads response)
//   slave  : PUF core side (reads challenge, drives response)
// ---------------------------------------------------------------------------
interface puf_key_generator_if;
  logic [7:0] challenge;
  logic       response;

  modport master (output challenge, input response);
  modport slave  (input challenge, output response);
endinterface

// File: rtl/puf_key_generator.sv
// ---------------------------------------------------------------------------
// puf_key_generator
// Walks an 8-bit LFSR challenge sequence from a seed, holds each challenge for
// SETTLE cycles, samples the PUF response and shifts it into a KEY_W-bit key.
// The first sampled bit ends up as the key MSB.
//
// Parameters:
//   KEY_W  : key length in bits (1..255), one challenge per bit
//   SETTLE : cycles each challenge is held before sampling (1..255)
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   start     : single-cycle request, accepted only while idle
//   seed      : first challenge (8'h00 is replaced by 8'h01)
//   puf       : challenge/response link (master modport)
//   key       : collected key
//   key_valid : high from completion until the next accepted start
//   busy      : high while a collection is in progress
//
// Build option:
//   PUF_VOTE_EN : when defined, each bit is sampled three times on the same
//                 challenge and majority-voted (SAMPLE lasts three cycles).
// ---------------------------------------------------------------------------
module puf_key_generator #(
  parameter int KEY_W  = 32,
  parameter int SETTLE = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [7:0]              seed,
  puf_key_generator_if.master     puf,
  output logic [KEY_W-1:0]        key,
  output logic                    key_valid,
  output logic                    busy
);

  // SETTLE is a parameter name, so the states carry an S_ prefix.
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE} state_t;

  state_t     state, state_nxt;
  logic [7:0] settle_cnt;
  logic [7:0] bit_cnt;
  logic       load;       // start accepted this cycle
  logic       take;       // final sample cycle of the current bit
  logic       key_bit;    // bit shifted into the key when take=1
  logic       last_settle;
  logic       last_bit;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // x^8+x^6+x^5+x^4+1, shift left with feedback into bit 0
  function automatic logic [7:0] lfsr_next(input logic [7:0] c);
    return {c[6:0], c[7] ^ c[5] ^ c[4] ^ c[3]};
  endfunction

  assign last_settle = (settle_cnt == 8'(SETTLE - 1));
  assign last_bit    = (bit_cnt == 8'(KEY_W - 1));

`ifdef PUF_VOTE_EN
  logic [1:0] vote_cnt;
  logic [1:0] votes;      // first two samples of the current bit

  assign take    = (vote_cnt == 2'd2);
  assign key_bit = maj3(votes[0], votes[1], puf.response);
`else
  assign take    = 1'b1;
  assign key_bit = puf.response;
`endif

  // Next-state logic
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (last_settle) state_nxt = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (take) state_nxt = last_bit ? S_IDLE : S_SETTLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Datapath: challenge, key and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      puf.challenge <= 8'h00;
      key           <= '0;
      key_valid     <= 1'b0;
      settle_cnt    <= 8'd0;
      bit_cnt       <= 8'd0;
`ifdef PUF_VOTE_EN
      vote_cnt      <= 2'd0;
      votes         <= 2'b00;
`endif
    end else begin
      if (load) begin
        puf.challenge <= (seed == 8'h00) ? 8'h01 : seed;
        key           <= '0;
        key_valid     <= 1'b0;
        settle_cnt    <= 8'd0;
        bit_cnt       <= 8'd0;
`ifdef PUF_VOTE_EN
        vote_cnt      <= 2'd0;
`endif
      end else if (state == S_SETTLE) begin
        settle_cnt <= last_settle ? 8'd0 : settle_cnt + 8'd1;
      end else if (state == S_SAMPLE) begin
`ifdef PUF_VOTE_EN
        if (!take) begin
          votes[vote_cnt[0]] <= puf.response;
          vote_cnt           <= vote_cnt + 2'd1;
        end else begin
          vote_cnt <= 2'd0;
        end
`endif
        if (take) begin
          // Cast drops the outgoing MSB; also correct for KEY_W=1.
          key <= KEY_W'({key, key_bit});
          if (last_bit) begin
            key_valid <= 1'b1;
          end else begin
            bit_cnt       <= bit_cnt + 8'd1;
            puf.challenge <= lfsr_next(puf.challenge);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_puf_key_generator.sv
// ---------------------------------------------------------------------------
// tb_puf_key_generator
// Directed, table-driven bench for puf_key_generator with KEY_W=8, SETTLE=2.
// A behavioural PUF drives the response: constant 0, constant 1, or the
// parity of the challenge, optionally with individual samples inverted.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_puf_key_generator;
  localparam int KEY_W  = 8;
  localparam int SETTLE = 2;
`ifdef PUF_VOTE_EN
  localparam int CYC = SETTLE + 3;
`else
  localparam int CYC = SETTLE + 1;
`endif
  localparam int DONE = KEY_W * CYC;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [7:0]       seed = 8'h00;
  logic [KEY_W-1:0] key;
  logic             key_valid;
  logic             busy;

  puf_key_generator_if puf ();

  puf_key_generator #(.KEY_W(KEY_W), .SETTLE(SETTLE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .seed      (seed),
    .puf       (puf.master),
    .key       (key),
    .key_valid (key_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // PUF model: 0 = tied low, 1 = tied high, 2 = parity of challenge
  int   mode = 0;
  logic inv  = 1'b0;
  always_comb begin
    case (mode)
      0:       puf.response = 1'b0;
      1:       puf.response = 1'b1;
      default: puf.response = (^puf.challenge) ^ inv;
    endcase
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    string      name;
    logic [7:0] seed;
    int         mode;
    bit         poke;     // pulse start again while busy
    logic [7:0] exp_key;
  } vec_t;

  logic [7:0] chal_log [$];
  int         kv_busy_viol;

  // Starts a collection and runs until key_valid; cyc_out = edges after E0.
  // inj: 0 none, 1 one inverted vote per bit, 2 two inverted votes on bit 0
  task automatic run_collect(input logic [7:0] sd, input int md, input int inj,
                             input bit poke, output int cyc_out);
    int j, i;
    mode = md;
    inv  = 1'b0;
    chal_log.delete();
    kv_busy_viol = 0;
    @(negedge clk);
    seed  = sd;
    start = 1'b1;
    @(posedge clk);                       // E0
    #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    chal_log.push_back(puf.challenge);
    cyc_out = -1;
    for (int k = 1; k <= 4 * DONE; k++) begin
      j = ((k - 1) % 5) + 1;
      i = (k - 1) / 5;
      inv = (inj == 1 && j == 3 + (i % 3)) ||
            (inj == 2 && i == 0 && (j == 3 || j == 4));
      start = poke && (k == 4);
      @(posedge clk);
      #1;
      start = 1'b0;
      if (puf.challenge != chal_log[$]) chal_log.push_back(puf.challenge);
      if (busy && key_valid) kv_busy_viol++;
      if (key_valid) begin
        cyc_out = k;
        break;
      end
    end
    inv = 1'b0;
    if (cyc_out < 0) chk("timeout_key_valid", 32'd0, 32'd1);
  endtask

  vec_t vecs [5];
  int   cyc;
  logic [7:0] exp_chal [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};

  initial begin
    vecs[0] = '{"const_one",   8'h01, 1, 1'b0, 8'hFF};
    vecs[1] = '{"const_zero",  8'h01, 0, 1'b0, 8'h00};
    vecs[2] = '{"parity_s01",  8'h01, 2, 1'b0, 8'hF4};
    vecs[3] = '{"parity_s00",  8'h00, 2, 1'b1, 8'hF4};
    vecs[4] = '{"parity_s11",  8'h11, 2, 1'b0, 8'h4C};

    // Reset state
    #3;
    chk("rst_challenge", puf.challenge, 8'h00);
    chk("rst_key",       key,           8'h00);
    chk("rst_key_valid", key_valid,     1'b0);
    chk("rst_busy",      busy,          1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[n]) begin
      run_collect(vecs[n].seed, vecs[n].mode, 0, vecs[n].poke, cyc);
      chk({vecs[n].name, "_key"},     key,       vecs[n].exp_key);
      chk({vecs[n].name, "_cycles"},  cyc,       DONE);
      chk({vecs[n].name, "_busy"},    busy,      1'b0);
      chk({vecs[n].name, "_kv_busy"}, kv_busy_viol, 0);
      if (n == 2) begin
        chk("chal_count", chal_log.size(), 8);
        for (int c = 0; c < 8 && c < chal_log.size(); c++)
          chk($sformatf("chal_%0d", c), chal_log[c], exp_chal[c]);
      end
    end

    // key_valid and key held while idle
    repeat (3) @(posedge clk);
    #1;
    chk("hold_key_valid", key_valid, 1'b1);
    chk("hold_key",       key,       8'h4C);

    // Restart after completion: key_valid drops on the accepting edge
    mode = 1;
    @(negedge clk);
    seed  = 8'h01;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("restart_key_valid", key_valid, 1'b0);
    chk("restart_busy",      busy,      1'b1);
    chk("restart_key",       key,       8'h00);

    // Asynchronous reset mid-collection, between clock edges
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_challenge", puf.challenge, 8'h00);
    chk("arst_key",       key,           8'h00);
    chk("arst_key_valid", key_valid,     1'b0);
    chk("arst_busy",      busy,          1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // A fresh run after the abort behaves normally
    run_collect(8'h01, 2, 0, 1'b0, cyc);
    chk("post_arst_key",    key, 8'hF4);
    chk("post_arst_cycles", cyc, DONE);

`ifdef PUF_VOTE_EN
    run_collect(8'h01, 2, 1, 1'b0, cyc);
    chk("vote_single_key",    key, 8'hF4);
    chk("vote_single_cycles", cyc, 40);
    run_collect(8'h01, 2, 2, 1'b0, cyc);
    chk("vote_double_key",    key, 8'h74);
    chk("vote_double_cycles", cyc, 40);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/puf_key_generator.md
# puf_key_generator

Sequential challenge driver and response collector for the 8-bit-challenge / 1-bit-response PUF core. On a start request it walks an 8-bit LFSR challenge sequence from a seed, holds each challenge for a programmable settle time, samples the PUF response and shifts it into a KEY_W-bit key register. It sits between the PUF core and key-consuming logic and is the initiator side of the challenge/response interface.

## Interface
- KEY_W, 32: key length in bits, one challenge per bit; legal range 1..255.
- SETTLE, 2: cycles each challenge is held before sampling; legal range 1..255.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request; accepted only when busy=0.
- seed  input  8  first challenge; 8'h00 is substituted by 8'h01.
- response  input  1  PUF response for the current challenge.
- challenge  output  8  challenge driven to the PUF, registered.
- key  output  KEY_W  collected key; first sampled bit is the MSB.
- key_valid  output  1  level; high from completion until the next accepted start.
- busy  output  1  high while a collection is in progress.

## Operation
- States: IDLE, SETTLE, SAMPLE.
- IDLE: busy=0. When start=1, load challenge<=(seed==0 ? 8'h01 : seed). Clear key, key_valid, bit counter and settle counter. Go to SETTLE.
- SETTLE: busy=1. challenge is held. The settle counter counts 0..SETTLE-1. On the last count, go to SAMPLE.
- SAMPLE (one cycle, or three with voting): key<={key[KEY_W-2:0], bit}.
  - If bit_cnt==KEY_W-1: set key_valid<=1 and go to IDLE. challenge keeps its last value.
  - Otherwise: bit_cnt++, challenge<={challenge[6:0], challenge[7]^challenge[5]^challenge[4]^challenge[3]}, go to SETTLE.
- The LFSR polynomial x^8+x^6+x^5+x^4+1 is maximal length, so the all-zero state is never entered.
- bit_cnt is 8 bits wide. key is never partially valid: key_valid=0 while busy=1.
- start while busy=1 is ignored, with no effect on state or counters.
- start in IDLE with key_valid=1 restarts collection and clears key_valid on the same edge.

## Timing
- Reset values: challenge=8'h00, key=0, key_valid=0, busy=0, state IDLE. All counters are 0.
- Reset is asynchronous. Asserting it mid-collection aborts immediately; no partial key is retained.
- If start is sampled at edge E0:
  - busy rises after E0.
  - Each bit takes SETTLE+1 cycles, or SETTLE+3 with voting.
  - key_valid rises and busy falls at edge E0 + KEY_W*(SETTLE+1), or E0 + KEY_W*(SETTLE+3) with voting.
- challenge changes only at the SAMPLE→SETTLE transition and on start. response is sampled at least SETTLE cycles after challenge changes.

## Configuration
- PUF_VOTE_EN defined: SAMPLE lasts 3 cycles with the challenge held. The three response samples are majority-voted (2 of 3) into one key bit.
- PUF_VOTE_EN undefined: a single response sample per challenge.
- Ports and state names are identical in both builds.

## Test plan
- Reset check: assert rst_n=0 mid-run at arbitrary times → outputs return to challenge=00, key=0, key_valid=0, busy=0 without waiting for a clock edge.
- Constant response: KEY_W=8, SETTLE=2, seed=8'h01, response tied to 1, start at E0 → key_valid at E0+24, key=8'hFF. With response tied to 0 → key=8'h00.
- Parity PUF model: response=^challenge, KEY_W=8, seed=8'h01 → challenges 01,02,04,08,11,23,47,8E in order, key=8'hF4, key_valid held until the next start.
- Seed zero and restart:
  - seed=8'h00 → identical to the 8'h01 result (8'hF4).
  - start pulsed while busy → ignored; completion time unchanged.
  - start after completion → key_valid drops on the next edge.
- Voting build (PUF_VOTE_EN), KEY_W=8, SETTLE=2:
  - Parity model with one injected inverted sample per bit → key=8'hF4, key_valid at E0+40.
  - Two inverted samples on bit 0 → key=8'h74.
